// File: rtl/riscv_lsu_ctrl.sv
// riscv_lsu_ctrl: RV32I load/store sequencer for a single-port data memory.
// Optional request timeout is enabled by defining LSU_TIMEOUT_EN.
module riscv_lsu_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [4:0]            req_rd,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [3:0]            mem_be_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [4:0]            rsp_rd,
    output logic                  misalign_o,
    output logic                  bus_err_o,
    output logic                  busy_o
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, ERR} state_e;
    state_e                state_q, state_d;
    logic                  st_q, bad, tmo;
    logic [2:0]            f3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q, lane, ext, wrep;
    logic [4:0]            rd_q;
    logic [3:0]            be;

    // Illegal funct3 encodings are reported through the same fault path as misalignment.
    assign bad = (req_is_store ? req_funct3 > 3'd2 : (req_funct3 == 3'd3 || req_funct3[2:1] == 2'b11))
              || (req_funct3[1:0] == 2'b01 && req_addr[0])
              || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = req_valid ? (bad ? ERR : REQ) : IDLE;
            REQ:     state_d = tmo ? IDLE : (mem_gnt_i ? WAIT : REQ);
            WAIT:    state_d = tmo ? IDLE : (mem_rvalid_i ? RESP : WAIT);
            default: state_d = IDLE;
        endcase
    end

    assign lane = mem_rdata_i >> {addr_q[1:0], 3'b000};
    assign ext  = f3_q[1:0] == 2'b00 ? {{24{lane[7] & ~f3_q[2]}}, lane[7:0]}
                : f3_q[1:0] == 2'b01 ? {{16{lane[15] & ~f3_q[2]}}, lane[15:0]} : lane;
    assign be   = f3_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0]
                : f3_q[1:0] == 2'b01 ? 4'b0011 << {addr_q[1], 1'b0} : 4'b1111;
    assign wrep = f3_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}}
                : f3_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            st_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid) begin
                st_q    <= req_is_store;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rd_q    <= req_rd;
            end
            if (state_q == WAIT && mem_rvalid_i) rdata_q <= st_q ? '0 : ext;
        end
    end

    assign req_ready   = state_q == IDLE;
    assign busy_o      = state_q != IDLE;
    assign mem_req_o   = state_q == REQ;
    assign mem_we_o    = mem_req_o & st_q;
    assign mem_addr_o  = mem_req_o ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign mem_be_o    = mem_req_o ? be : 4'b0000;
    assign mem_wdata_o = mem_we_o ? wrep : '0;
    assign rsp_valid   = state_q == RESP;
    assign rsp_rdata   = rsp_valid ? rdata_q : '0;
    assign rsp_rd      = (rsp_valid && !st_q) ? rd_q : 5'd0;
    assign misalign_o  = state_q == ERR;

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1) > 8 ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0] cnt_q;
    logic          berr_q;
    // Counter sits at zero in IDLE, so it restarts for every accepted op.
    assign tmo       = (state_q == REQ || state_q == WAIT) && cnt_q == CW'(TIMEOUT_CYCLES - 1);
    assign bus_err_o = berr_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            berr_q <= 1'b0;
        end else begin
            cnt_q  <= (state_q == REQ || state_q == WAIT) ? cnt_q + 1'b1 : '0;
            berr_q <= tmo;
        end
    end
`else
    assign tmo       = 1'b0;
    assign bus_err_o = 1'b0;
`endif
endmodule
